irq_controller: RTL and testbench

Interrupt controller that sits between the external interrupt sources and `mips_top`, on the same path that drives the core's 4-bit `INT` input. It synchronizes four asynchronous request lines, latches rising edges as pending, applies a software mask, and presents one prioritized request to the core. A request is held until the core acknowledges it; the controller then blocks further requests until the core signals end-of-interrupt. Mask and pending state are reachable through a small register port on the data-memory side.

---
 rtl/irq_controller.sv | 193 +++++++++++++++++++
 tb/tb_irq_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//
// Sits between the external interrupt sources and the core's INT request.
// Four asynchronous request lines are synchronized, their rising edges are
// latched as pending, a software mask selects which may interrupt, and a
// single fixed-priority request (lowest index wins) is presented to the core.
// The presented request is held until the core acknowledges it. No further
// request is raised until the core signals end-of-interrupt.
//
// Ports:
//   clk        - single clock for all logic
//   rst        - asynchronous, active-high reset
//   int_in     - asynchronous request lines, rising edge is the event
//   irq        - request to the core (high only in REQ)
//   irq_id     - index of the presented source, valid while irq=1
//   ack        - one-cycle pulse: core has taken the exception
//   eoi        - one-cycle pulse: handler has returned
//   in_service - high between ack and eoi
//   reg_we     - register write strobe
//   reg_addr   - 0 MASK, 1 PENDING (write-1-to-clear), 2 STATUS (read-only)
//   reg_wdata  - write data, bits [NUM_IRQ-1:0] used
//   reg_rdata  - combinational read data, unused bits read as 0
// -----------------------------------------------------------------------------
module irq_controller #(
  parameter int NUM_IRQ     = 4,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] int_in,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  input  logic               ack,
  input  logic               eoi,
  output logic               in_service,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;

  // Synchronizer chain; stage 0 is the first to see int_in.
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_reg;
  // Delayed copy of the last synchronizer stage, used for edge detection.
  logic [NUM_IRQ-1:0] prev_reg;

  logic [NUM_IRQ-1:0] mask_reg;
  logic [NUM_IRQ-1:0] pending_reg;
  logic [NUM_IRQ-1:0] pending_next;
  logic [ID_W-1:0]    id_reg;
  logic [ID_W-1:0]    id_next;
  state_t             state_reg;
  state_t             state_next;

  logic [NUM_IRQ-1:0] sync_out;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] wr_clr;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [ID_W-1:0]    prio_id;

  // Only the low bits of the write data carry register content.
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata[31:NUM_IRQ];

  // ---------------------------------------------------------------------------
  // Synchronizer and edge detect. Clearing to 0 on reset means a line held
  // high through reset is seen as one fresh edge after release.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg[0] <= int_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_reg;

  // ---------------------------------------------------------------------------
  // Pending / mask registers
  // ---------------------------------------------------------------------------
  assign wr_clr = (reg_we && reg_addr == ADDR_PENDING) ? reg_wdata[NUM_IRQ-1:0] : '0;

  // A fresh edge is OR-ed in after the clears so it survives a same-cycle
  // software clear or acknowledge of the same bit.
  assign pending_next = (pending_reg & ~(wr_clr | ack_clr)) | rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_reg    <= '0;
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
      if (reg_we && reg_addr == ADDR_MASK) begin
        mask_reg <= reg_wdata[NUM_IRQ-1:0];
      end
    end
  end

  assign eligible = pending_reg & mask_reg;

  // Fixed priority: scanning downwards lets the lowest eligible index win.
  always_comb begin
    prio_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        prio_id = ID_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    ack_clr    = '0;
    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          state_next = REQ;
          id_next    = prio_id;
        end
      end
      REQ: begin
        // The core has committed once it acks, so ack takes precedence
        // over a withdrawal seen in the same cycle.
        if (ack) begin
          state_next = SERVICE;
          ack_clr    = {{(NUM_IRQ-1){1'b0}}, 1'b1} << id_reg;
        end else if (!eligible[id_reg]) begin
          state_next = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign irq        = (state_reg == REQ);
  assign in_service = (state_reg == SERVICE);
  assign irq_id     = id_reg;

  // ---------------------------------------------------------------------------
  // Register read port
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_MASK:    reg_rdata[NUM_IRQ-1:0] = mask_reg;
      ADDR_PENDING: reg_rdata[NUM_IRQ-1:0] = pending_reg;
      ADDR_STATUS:  reg_rdata[ID_W+3:0]    = {in_service, irq, id_reg, 2'b00};
      default:      reg_rdata              = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
//
// Directed testbench for irq_controller with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, so every value read reflects the state after the preceding edge.
// -----------------------------------------------------------------------------
module tb_irq_controller;

  logic        clk;
  logic        rst;
  logic [3:0]  int_in;
  logic        irq;
  logic [1:0]  irq_id;
  logic        ack;
  logic        eoi;
  logic        in_service;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  int n_checks;
  int n_fails;
  logic [31:0] rd_val;

  irq_controller #(
    .NUM_IRQ     (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .int_in     (int_in),
    .irq        (irq),
    .irq_id     (irq_id),
    .ack        (ack),
    .eoi        (eoi),
    .in_service (in_service),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Register write; it takes effect on the edge inside this task.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick();
    reg_we    = 1'b0;
    reg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  // One-cycle pulse on the given lines; returns just after capture edge E0.
  task automatic pulse_in(input logic [3:0] v);
    int_in = v;
    tick();
    int_in = 4'b0000;
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    int_in    = '0;
    ack       = 1'b0;
    eoi       = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    ticks(3);
    rst = 1'b0;
    tick();

    // ---------------- reset state ----------------
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_irq_id", {30'b0, irq_id}, 32'd0);
    check("rst_in_service", {31'b0, in_service}, 32'd0);
    rd(2'd0, rd_val); check("rst_mask", rd_val, 32'd0);
    rd(2'd1, rd_val); check("rst_pending", rd_val, 32'd0);
    rd(2'd2, rd_val); check("rst_status", rd_val, 32'd0);

    // STATUS is read-only: a write must not disturb MASK or STATUS.
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, rd_val); check("status_ro", rd_val, 32'd0);
    rd(2'd0, rd_val); check("status_ro_mask", rd_val, 32'd0);

    // ---------------- basic request / ack / eoi ----------------
    wr(2'd0, 32'h4);
    pulse_in(4'b0100);                       // after E0
    ticks(2);                                // after E2
    check("basic_irq_e2", {31'b0, irq}, 32'd0);
    rd(2'd1, rd_val); check("basic_pending", rd_val, 32'h4);
    tick();                                  // after E3
    check("basic_irq_e3", {31'b0, irq}, 32'd1);
    check("basic_id", {30'b0, irq_id}, 32'd2);
    rd(2'd2, rd_val); check("basic_status", rd_val, 32'h18);
    pulse_ack();
    check("basic_ack_irq", {31'b0, irq}, 32'd0);
    check("basic_ack_insvc", {31'b0, in_service}, 32'd1);
    rd(2'd1, rd_val); check("basic_ack_pending", rd_val, 32'd0);
    pulse_eoi();
    check("basic_eoi_insvc", {31'b0, in_service}, 32'd0);
    ticks(2);
    check("basic_idle_irq", {31'b0, irq}, 32'd0);

    // ---------------- priority ----------------
    wr(2'd0, 32'hF);
    pulse_in(4'b1010);
    ticks(3);                                // after E3
    check("prio_irq", {31'b0, irq}, 32'd1);
    check("prio_id_first", {30'b0, irq_id}, 32'd1);
    pulse_ack();
    rd(2'd1, rd_val); check("prio_pending_after_ack", rd_val, 32'h8);
    pulse_eoi();                             // after Ee
    check("prio_irq_at_eoi", {31'b0, irq}, 32'd0);
    tick();                                  // after Ee+1
    check("prio_irq_reassert", {31'b0, irq}, 32'd1);
    check("prio_id_second", {30'b0, irq_id}, 32'd3);
    pulse_ack();
    pulse_eoi();
    rd(2'd1, rd_val); check("prio_pending_empty", rd_val, 32'd0);

    // ---------------- masking ----------------
    wr(2'd0, 32'h0);
    pulse_in(4'b0001);
    ticks(4);
    rd(2'd1, rd_val); check("mask_pending", rd_val, 32'h1);
    check("mask_irq_blocked", {31'b0, irq}, 32'd0);
    wr(2'd0, 32'h1);                         // after write edge W
    check("mask_irq_at_w", {31'b0, irq}, 32'd0);
    tick();                                  // after W+1
    check("mask_irq_enabled", {31'b0, irq}, 32'd1);
    check("mask_id", {30'b0, irq_id}, 32'd0);
    pulse_ack();
    pulse_eoi();

    // ---------------- withdrawal ----------------
    wr(2'd0, 32'h2);
    pulse_in(4'b0010);
    ticks(3);
    check("wd_irq", {31'b0, irq}, 32'd1);
    check("wd_id", {30'b0, irq_id}, 32'd1);
    wr(2'd1, 32'h2);                         // w1c at edge W
    rd(2'd1, rd_val); check("wd_pending_cleared", rd_val, 32'd0);
    tick();                                  // after W+1
    check("wd_irq_dropped", {31'b0, irq}, 32'd0);
    rd(2'd2, rd_val); check("wd_state_idle", rd_val & 32'h30, 32'd0);

    // ---------------- clear racing a new edge ----------------
    pulse_in(4'b0010);
    ticks(3);
    check("race_setup_irq", {31'b0, irq}, 32'd1);
    pulse_in(4'b0010);                       // after F0
    tick();                                  // after F1; edge seen before F2
    wr(2'd1, 32'h2);                         // clear sampled at F2
    rd(2'd1, rd_val); check("race_pending_kept", rd_val, 32'h2);
    check("race_irq_f2", {31'b0, irq}, 32'd1);
    tick();
    check("race_irq_f3", {31'b0, irq}, 32'd1);
    check("race_id", {30'b0, irq_id}, 32'd1);
    pulse_ack();
    pulse_eoi();
    rd(2'd1, rd_val); check("race_pending_done", rd_val, 32'd0);

    // ---------------- level versus edge ----------------
    wr(2'd0, 32'h4);
    int_in = 4'b0100;
    ticks(4);
    check("lvl_irq", {31'b0, irq}, 32'd1);
    check("lvl_id", {30'b0, irq_id}, 32'd2);
    pulse_ack();
    pulse_eoi();
    ticks(14);                               // 20 edges with the line high
    check("lvl_no_retrigger", {31'b0, irq}, 32'd0);
    rd(2'd1, rd_val); check("lvl_pending_empty", rd_val, 32'd0);
    int_in = 4'b0000;
    ticks(2);
    int_in = 4'b0100;
    ticks(4);
    check("lvl_new_irq", {31'b0, irq}, 32'd1);
    check("lvl_new_id", {30'b0, irq_id}, 32'd2);
    pulse_ack();
    pulse_eoi();
    ticks(5);
    check("lvl_single_request", {31'b0, irq}, 32'd0);
    int_in = 4'b0000;
    ticks(3);

    // ---------------- reset mid-service ----------------
    wr(2'd0, 32'hC);
    pulse_in(4'b0100);
    ticks(3);
    pulse_ack();
    pulse_in(4'b1000);
    ticks(3);
    check("rstmid_insvc", {31'b0, in_service}, 32'd1);
    rd(2'd1, rd_val); check("rstmid_pending", rd_val, 32'h8);
    #2;
    rst = 1'b1;                              // between clock edges
    #1;
    check("rstmid_irq", {31'b0, irq}, 32'd0);
    check("rstmid_insvc_clr", {31'b0, in_service}, 32'd0);
    rd(2'd0, rd_val); check("rstmid_mask", rd_val, 32'd0);
    rd(2'd1, rd_val); check("rstmid_pending_clr", rd_val, 32'd0);
    tick();
    rst = 1'b0;
    ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
